// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch memory responder: req/gnt/rvalid slave over a word array.
// Define IBEX_IMEM_GNT_STALL_EN to add LFSR-driven pseudo-random grant stalls.
module ibex_instr_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_req_i,
    output logic                        instr_gnt_o,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        load_we_i,
    input  logic [$clog2(MemWords)-1:0] load_addr_i,
    input  logic [31:0]                 load_wdata_i,
    output logic                        busy_o
);

    localparam int unsigned IdxW = $clog2(MemWords);
    // 33-bit range end so a window ending at 4 GiB does not wrap to zero
    localparam logic [32:0] EndAddr =
        {1'b0, BaseAddr} + (33'(MemWords) << 2);

    logic [31:0]              mem_q [MemWords];
    logic [2:0]               cnt_q;
    logic [2:0]               cnt_d;
    logic                     stall_ok;
    logic                     grant;
    logic                     req_err;
    logic [IdxW-1:0]          idx;
    logic [31:0]              rd_word;
    logic [Latency-1:0]       vld_q;
    logic [Latency-1:0]       err_q;
    logic [Latency-1:0][31:0] data_q;

`ifdef IBEX_IMEM_GNT_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign stall_ok = ~lfsr_q[0];
`else
    assign stall_ok = 1'b1;
`endif

    assign instr_gnt_o = instr_req_i
                       & (cnt_q < 3'(MaxOutstanding))
                       & stall_ok;
    assign grant       = instr_req_i & instr_gnt_o;

    always_comb begin
        req_err = ({1'b0, instr_addr_i} < {1'b0, BaseAddr})
                | ({1'b0, instr_addr_i} >= EndAddr);
        idx     = IdxW'((instr_addr_i - BaseAddr) >> 2);
        // combinational read sees the array before a same-edge load write
        rd_word = req_err ? 32'h0 : mem_q[idx];
    end

    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            err_q  <= '0;
            data_q <= '0;
        end else begin
            for (int unsigned i = 1; i < Latency; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
            vld_q[0]  <= grant;
            err_q[0]  <= grant & req_err;
            data_q[0] <= grant ? rd_word : 32'h0;
        end
    end

    assign instr_rvalid_o = vld_q[Latency-1];
    assign instr_err_o    = vld_q[Latency-1] & err_q[Latency-1];
    assign instr_rdata_o  = vld_q[Latency-1] ? data_q[Latency-1] : 32'h0;

    always_comb begin
        cnt_d = cnt_q + {2'b0, grant} - {2'b0, instr_rvalid_o};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 3'd0);

endmodule
